mem_arbiter: RTL and testbench

- Sits directly downstream of the core's two memory ports: instruction fetch and data load/store.
- Merges both into one memory/cache port.
- Each side uses pulse-enable request/response handshakes. The block buffers one request per side, grants one at a time, and routes the response back to its owner.
- Payloads are opaque memreq/memresp structs; the block never inspects their fields.

---
 rtl/mem_arbiter_pkg.sv | 38 +++
 rtl/mem_arbiter_req.sv | 39 +++
 rtl/mem_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter slice: opaque request/response payloads,
// arbiter state encoding and the grant-selection helper.
// Combinational helpers only; no storage and no flow control live here.
package mem_arbiter_pkg;

  // Payloads pass through the arbiter untouched; fields exist for the producers/consumers.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        we;
  } memreq;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } memresp;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BUSY_FETCH = 2'd1,
    BUSY_MEM   = 2'd2
  } arb_state_e;

  // Returns 1 when the data (mem) side should be granted.
  // Under contention: fixed priority picks mem; round-robin picks whichever
  // side did not win the previous contended decision.
  function automatic logic pick_mem(input logic fetch_vld,
                                    input logic mem_vld,
                                    input logic rr_en,
                                    input logic mem_won_last);
    if (fetch_vld && mem_vld) begin
      return rr_en ? !mem_won_last : 1'b1;
    end
    return mem_vld;
  endfunction

endpackage

// File: rtl/mem_arbiter_req.sv
// req_slot: one-entry holding register for an upstream request, with overflow flag.
// Latency: loaded value visible the cycle after the load pulse.
// Backpressure: none; a load while occupied (or while the side is outstanding) is dropped and flagged.
// Ports: load/load_dat capture a request, clr empties the slot, busy marks the side as
//        outstanding downstream, vld/dat present the held request, overflow flags a dropped load.
module req_slot
  import mem_arbiter_pkg::*;
(
  input  logic  clk,
  input  logic  rstn,
  input  logic  load,
  input  memreq load_dat,
  input  logic  clr,
  input  logic  busy,
  output logic  vld,
  output memreq dat,
  output logic  overflow
);

  // A side may only have one request in flight, whether it is still held here
  // or already issued downstream.
  assign overflow = load & (vld | busy);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld <= 1'b0;
      dat <= '0;
    end else begin
      // Load and clear never coincide usefully: a load with vld set is an overflow.
      if (load && !overflow) begin
        vld <= 1'b1;
        dat <= load_dat;
      end else if (clr) begin
        vld <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: merges fetch and data memory ports onto one downstream memory port.
// Latency: request pulse -> bus request 2 cycles; bus response -> upstream response 1 cycle.
// Backpressure: none (pulse handshakes); one request buffered per side, extra requests dropped and flagged.
// Ports: fetch_* and mem_* are the upstream request/response pairs, bus_* the downstream pair,
//        protocol_error is a sticky flag for an upstream request made while that side was busy.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ROUND_ROBIN = 0
) (
  input  logic   clk,
  input  logic   rstn,
  input  logic   fetch_request_enable,
  input  memreq  fetch_request,
  output logic   fetch_response_enable,
  output memresp fetch_response,
  input  logic   mem_request_enable,
  input  memreq  mem_request,
  output logic   mem_response_enable,
  output memresp mem_response,
  output logic   bus_request_enable,
  output memreq  bus_request,
  input  logic   bus_response_enable,
  input  memresp bus_response,
  output logic   protocol_error
);

  localparam logic RR_EN = (ROUND_ROBIN != 0);

  arb_state_e state_q, state_d;

  logic  fetch_vld, mem_vld;
  logic  fetch_ovf, mem_ovf;
  memreq fetch_dat, mem_dat;
  logic  grant, grant_mem;
  logic  arb_window;
  // Side that won the most recent contended grant; reset = fetch, so mem wins first.
  logic  mem_won_last;

  req_slot u_fetch_slot (
    .clk      (clk),
    .rstn     (rstn),
    .load     (fetch_request_enable),
    .load_dat (fetch_request),
    .clr      (grant & ~grant_mem),
    .busy     (state_q == BUSY_FETCH),
    .vld      (fetch_vld),
    .dat      (fetch_dat),
    .overflow (fetch_ovf)
  );

  req_slot u_mem_slot (
    .clk      (clk),
    .rstn     (rstn),
    .load     (mem_request_enable),
    .load_dat (mem_request),
    .clr      (grant & grant_mem),
    .busy     (state_q == BUSY_MEM),
    .vld      (mem_vld),
    .dat      (mem_dat),
    .overflow (mem_ovf)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The bus is free either when idle or in the cycle its response arrives;
  // in the latter case a held request is issued back-to-back.
  always_comb begin
    state_d    = state_q;
    grant      = 1'b0;
    grant_mem  = 1'b0;
    arb_window = 1'b0;
    case (state_q)
      IDLE:                 arb_window = 1'b1;
      BUSY_FETCH, BUSY_MEM: arb_window = bus_response_enable;
      default:              arb_window = 1'b1;
    endcase
    if (arb_window) begin
      if (fetch_vld || mem_vld) begin
        grant     = 1'b1;
        grant_mem = pick_mem(fetch_vld, mem_vld, RR_EN, mem_won_last);
        state_d   = grant_mem ? BUSY_MEM : BUSY_FETCH;
      end else begin
        state_d   = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus_request_enable    <= 1'b0;
      bus_request           <= '0;
      fetch_response_enable <= 1'b0;
      fetch_response        <= '0;
      mem_response_enable   <= 1'b0;
      mem_response          <= '0;
      protocol_error        <= 1'b0;
      mem_won_last          <= 1'b0;
    end else begin
      bus_request_enable <= grant;
      if (grant) begin
        bus_request <= grant_mem ? mem_dat : fetch_dat;
      end
      // The pointer only moves on contended decisions, so simultaneous pairs
      // alternate their leader from one round to the next.
      if (grant && fetch_vld && mem_vld) begin
        mem_won_last <= grant_mem;
      end

      // A response with no owner (IDLE) is discarded.
      fetch_response_enable <= bus_response_enable && (state_q == BUSY_FETCH);
      if (bus_response_enable && (state_q == BUSY_FETCH)) begin
        fetch_response <= bus_response;
      end
      mem_response_enable <= bus_response_enable && (state_q == BUSY_MEM);
      if (bus_response_enable && (state_q == BUSY_MEM)) begin
        mem_response <= bus_response;
      end

      if (fetch_ovf || mem_ovf) begin
        protocol_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: fixed-priority instance [0] and round-robin instance [1],
// directed scenarios followed by randomized traffic against a transaction-level model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  logic   fe  [2];
  memreq  fd  [2];
  logic   me  [2];
  memreq  md  [2];
  logic   be  [2];
  memresp bd  [2];
  logic   fre [2];
  memresp frd [2];
  logic   mre [2];
  memresp mrd [2];
  logic   bre [2];
  memreq  brd [2];
  logic   perr[2];

  mem_arbiter #(.ROUND_ROBIN(0)) u_fixed (
    .clk(clk), .rstn(rstn),
    .fetch_request_enable(fe[0]), .fetch_request(fd[0]),
    .fetch_response_enable(fre[0]), .fetch_response(frd[0]),
    .mem_request_enable(me[0]), .mem_request(md[0]),
    .mem_response_enable(mre[0]), .mem_response(mrd[0]),
    .bus_request_enable(bre[0]), .bus_request(brd[0]),
    .bus_response_enable(be[0]), .bus_response(bd[0]),
    .protocol_error(perr[0])
  );

  mem_arbiter #(.ROUND_ROBIN(1)) u_rr (
    .clk(clk), .rstn(rstn),
    .fetch_request_enable(fe[1]), .fetch_request(fd[1]),
    .fetch_response_enable(fre[1]), .fetch_response(frd[1]),
    .mem_request_enable(me[1]), .mem_request(md[1]),
    .mem_response_enable(mre[1]), .mem_response(mrd[1]),
    .bus_request_enable(bre[1]), .bus_request(brd[1]),
    .bus_response_enable(be[1]), .bus_response(bd[1]),
    .protocol_error(perr[1])
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: per instance, held requests per side (0 fetch, 1 mem),
  // the side currently owning the bus (-1 none), last contended winner, and
  // the outputs expected after the next clock edge.
  bit     m_pend   [2][2];
  memreq  m_pdat   [2][2];
  int     m_owner  [2];
  int     m_rrlast [2];
  bit     e_bus_en [2];
  memreq  e_bus_dat[2];
  bit     e_resp_en [2][2];
  memresp e_resp_dat[2][2];
  bit     e_err    [2];
  int     obs_bus  [2];
  int     obs_mresp[2];

  task automatic model_reset(input int d);
    for (int x = 0; x < 2; x++) begin
      m_pend[d][x]     = 1'b0;
      m_pdat[d][x]     = '0;
      e_resp_en[d][x]  = 1'b0;
      e_resp_dat[d][x] = '0;
    end
    m_owner[d]   = -1;
    m_rrlast[d]  = 0;
    e_bus_en[d]  = 1'b0;
    e_bus_dat[d] = '0;
    e_err[d]     = 1'b0;
  endtask

  task automatic model_step(input int d, input bit rf, input memreq df, input bit rm,
                            input memreq dm, input bit rb, input memresp db);
    bit    req [2];
    memreq rd  [2];
    bit    viol[2];
    bit    bus_free;
    int    win;
    int    own;
    req[0] = rf; req[1] = rm; rd[0] = df; rd[1] = dm;
    e_bus_en[d] = 1'b0;
    e_resp_en[d][0] = 1'b0;
    e_resp_en[d][1] = 1'b0;
    for (int x = 0; x < 2; x++) viol[x] = req[x] && (m_pend[d][x] || m_owner[d] == x);
    bus_free = (m_owner[d] < 0);
    if (m_owner[d] >= 0 && rb) begin
      own = m_owner[d];
      e_resp_en[d][own]  = 1'b1;
      e_resp_dat[d][own] = db;
      m_owner[d] = -1;
      bus_free   = 1'b1;
    end
    if (bus_free) begin
      win = -1;
      if (m_pend[d][0] && m_pend[d][1]) begin
        win = (d == 1) ? 1 - m_rrlast[d] : 1;
        m_rrlast[d] = win;
      end else if (m_pend[d][1]) begin
        win = 1;
      end else if (m_pend[d][0]) begin
        win = 0;
      end
      if (win >= 0) begin
        e_bus_en[d]  = 1'b1;
        e_bus_dat[d] = m_pdat[d][win];
        m_pend[d][win] = 1'b0;
        m_owner[d] = win;
      end
    end
    for (int x = 0; x < 2; x++) begin
      if (req[x]) begin
        if (viol[x]) e_err[d] = 1'b1;
        else begin
          m_pend[d][x] = 1'b1;
          m_pdat[d][x] = rd[x];
        end
      end
    end
  endtask

  task automatic compare(input int d);
    check_val($sformatf("d%0d_bus_req_en", d), bre[d], e_bus_en[d]);
    if (e_bus_en[d]) check_val($sformatf("d%0d_bus_req", d), brd[d], e_bus_dat[d]);
    check_val($sformatf("d%0d_fetch_resp_en", d), fre[d], e_resp_en[d][0]);
    check_val($sformatf("d%0d_fetch_resp", d), frd[d], e_resp_dat[d][0]);
    check_val($sformatf("d%0d_mem_resp_en", d), mre[d], e_resp_en[d][1]);
    check_val($sformatf("d%0d_mem_resp", d), mrd[d], e_resp_dat[d][1]);
    check_val($sformatf("d%0d_protocol_error", d), perr[d], e_err[d]);
  endtask

  // One clock cycle on instance d: drive inputs, advance the model, sample after the edge.
  task automatic cyc(input int d, input bit rf, input memreq df, input bit rm,
                     input memreq dm, input bit rb, input memresp db);
    fe[d] = rf; fd[d] = df; me[d] = rm; md[d] = dm; be[d] = rb; bd[d] = db;
    model_step(d, rf, df, rm, dm, rb, db);
    @(posedge clk);
    #1;
    fe[d] = 1'b0; me[d] = 1'b0; be[d] = 1'b0;
    if (bre[d]) obs_bus[d]++;
    if (mre[d]) obs_mresp[d]++;
    compare(d);
  endtask

  task automatic idle(input int d, input int n);
    for (int i = 0; i < n; i++) cyc(d, 1'b0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic resp(input int d, input memresp r);
    cyc(d, 1'b0, '0, 1'b0, '0, 1'b1, r);
  endtask

  function automatic memreq mk_req(input logic [31:0] a);
    memreq q;
    q.addr = a; q.wdata = ~a; q.wstrb = a[3:0]; q.we = a[4];
    return q;
  endfunction

  function automatic memresp mk_resp(input logic [31:0] v);
    memresp r;
    r.rdata = v; r.err = v[0];
    return r;
  endfunction

  memreq  a, f, m;
  memresp r, r2;
  int     exp_order [6] = '{1, 0, 0, 1, 1, 0};
  bit     mbusy [2];
  bit     bus_pend;
  int     bus_wait;
  bit     rf, rm, rb;

  initial begin
    for (int d = 0; d < 2; d++) begin
      fe[d] = 1'b0; fd[d] = '0; me[d] = 1'b0; md[d] = '0; be[d] = 1'b0; bd[d] = '0;
      obs_bus[d] = 0; obs_mresp[d] = 0;
      model_reset(d);
    end
    rstn = 1'b0;
    #1;
    check_val("reset_bus_req_en", bre[0], 1'b0);
    check_val("reset_protocol_error", perr[0], 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    compare(0);
    compare(1);

    // Single fetch: grant at cycle 2, response at cycle 6.
    a = mk_req(32'h0000_1000); r = mk_resp(32'hCAFE_0001);
    cyc(0, 1'b1, a, 1'b0, '0, 1'b0, '0);
    idle(0, 1);
    check_val("t1_grant_c2", bre[0], 1'b1);
    check_val("t1_grant_payload", brd[0], a);
    idle(0, 3);
    resp(0, r);
    check_val("t1_fetch_resp_c6", fre[0], 1'b1);
    check_val("t1_fetch_resp_dat", frd[0], r);
    check_val("t1_no_mem_resp", mre[0], 1'b0);

    // Simultaneous fetch+mem, fixed priority: mem first, back-to-back fetch.
    f = mk_req(32'h0000_2000); m = mk_req(32'h0000_8000);
    r = mk_resp(32'h1111_2222); r2 = mk_resp(32'h3333_4445);
    cyc(0, 1'b1, f, 1'b1, m, 1'b0, '0);
    idle(0, 1);
    check_val("t2_first_grant_mem", brd[0], m);
    idle(0, 2);
    resp(0, r);
    check_val("t2_mem_resp_c5", mre[0], 1'b1);
    check_val("t2_mem_resp_dat", mrd[0], r);
    check_val("t2_b2b_grant_c5", bre[0], 1'b1);
    check_val("t2_b2b_payload", brd[0], f);
    idle(0, 2);
    resp(0, r2);
    check_val("t2_fetch_resp_c8", fre[0], 1'b1);
    check_val("t2_fetch_resp_dat", frd[0], r2);

    // Bus response while idle is ignored; a new fetch still takes 2 cycles.
    resp(0, mk_resp(32'hDEAD_BEEF));
    check_val("t6_idle_resp_no_fetch", fre[0], 1'b0);
    check_val("t6_idle_resp_no_mem", mre[0], 1'b0);
    a = mk_req(32'h0000_4000);
    cyc(0, 1'b1, a, 1'b0, '0, 1'b0, '0);
    idle(0, 1);
    check_val("t6_grant_after_idle_resp", bre[0], 1'b1);
    resp(0, mk_resp(32'h0000_0006));

    // Double mem request: sticky error, one grant, one response.
    obs_bus[0] = 0; obs_mresp[0] = 0;
    m = mk_req(32'h0000_9000);
    cyc(0, 1'b0, '0, 1'b1, m, 1'b0, '0);
    idle(0, 1);
    cyc(0, 1'b0, '0, 1'b1, mk_req(32'h0000_9100), 1'b0, '0);
    check_val("t4_error_set", perr[0], 1'b1);
    idle(0, 1);
    resp(0, mk_resp(32'h4444_0000));
    idle(0, 4);
    check_val("t4_error_sticky", perr[0], 1'b1);
    check_val("t4_one_bus_req", obs_bus[0], 1);
    check_val("t4_one_mem_resp", obs_mresp[0], 1);

    // Reset while BUSY_FETCH: everything clears, late response discarded.
    a = mk_req(32'h0000_5000);
    cyc(0, 1'b1, a, 1'b0, '0, 1'b0, '0);
    idle(0, 1);
    rstn = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    check_val("t5_rst_bus_en", bre[0], 1'b0);
    check_val("t5_rst_bus_req", brd[0], 69'd0);
    check_val("t5_rst_fetch_en", fre[0], 1'b0);
    check_val("t5_rst_fetch_dat", frd[0], 33'd0);
    check_val("t5_rst_mem_en", mre[0], 1'b0);
    check_val("t5_rst_mem_dat", mrd[0], 33'd0);
    check_val("t5_rst_error", perr[0], 1'b0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    compare(0);
    resp(0, mk_resp(32'h5555_5555));
    check_val("t5_late_resp_dropped", fre[0], 1'b0);
    a = mk_req(32'h0000_6000);
    cyc(0, 1'b1, a, 1'b0, '0, 1'b0, '0);
    idle(0, 1);
    check_val("t5_fresh_grant", bre[0], 1'b1);
    check_val("t5_fresh_payload", brd[0], a);
    resp(0, mk_resp(32'h6666_0000));

    // Round-robin: three simultaneous rounds give M F F M M F.
    for (int rnd = 0; rnd < 3; rnd++) begin
      f = mk_req(32'h0000_3000 + 32'(rnd * 16));
      m = mk_req(32'h0000_A000 + 32'(rnd * 16));
      cyc(1, 1'b1, f, 1'b1, m, 1'b0, '0);
      idle(1, 1);
      check_val($sformatf("t3_round%0d_first", rnd), brd[1], (exp_order[2*rnd] == 1) ? m : f);
      resp(1, mk_resp(32'h7000_0000 + 32'(rnd)));
      check_val($sformatf("t3_round%0d_second", rnd), brd[1], (exp_order[2*rnd+1] == 1) ? m : f);
      resp(1, mk_resp(32'h7100_0000 + 32'(rnd)));
      idle(1, 1);
    end

    // Randomized traffic on both instances.
    for (int d = 0; d < 2; d++) begin
      mbusy[0] = 1'b0; mbusy[1] = 1'b0; bus_pend = 1'b0; bus_wait = 0;
      for (int i = 0; i < 1500; i++) begin
        rf = mbusy[0] ? ($urandom % 60 == 0) : ($urandom % 4 == 0);
        rm = mbusy[1] ? ($urandom % 60 == 0) : ($urandom % 4 == 0);
        if (rf) mbusy[0] = 1'b1;
        if (rm) mbusy[1] = 1'b1;
        rb = 1'b0;
        if (bus_pend) begin
          if (bus_wait == 0) begin
            rb = 1'b1;
            bus_pend = 1'b0;
          end else begin
            bus_wait--;
          end
        end else if (m_owner[d] < 0 && $urandom % 50 == 0) begin
          rb = 1'b1;
        end
        cyc(d, rf, mk_req($urandom), rm, mk_req($urandom), rb, mk_resp($urandom));
        if (e_bus_en[d]) begin
          bus_pend = 1'b1;
          bus_wait = $urandom_range(0, 3);
        end
        for (int x = 0; x < 2; x++) if (e_resp_en[d][x]) mbusy[x] = 1'b0;
      end
      idle(d, 8);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
